// File: rtl/mem_port_arbiter_pkg.sv
// Shared cache definitions: memory bundles and arbiter state.
// Imported by the L1/L2 arbitration logic.
package cache_def;

    localparam int ARB_MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic        valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Rotating priority picker: first requester at or after the
// pointer (with wrap-around) gets a one-hot grant.
module rr_priority_picker #(
    parameter int N_PORTS = 2,
    parameter int PW      = 1
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [N_PORTS-1:0] grant_o
);

    // Scan ports from the pointer, wrapping, and keep the first hit.
    always_comb begin : pick
        logic          found;
        int            j;
        logic [PW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N_PORTS) begin
                j = j - N_PORTS;
            end
            idx = PW'(j);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter sharing one downstream line channel among L1
// requesters; one outstanding transaction, registered capture.
module mem_port_arbiter
    import cache_def::*;
#(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int RR_MODE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_PORTS-1:0]    req_valid_i,
    input  logic [N_PORTS-1:0]    req_rw_i,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr_i,
    input  logic [N_PORTS*LINE_W-1:0] req_data_i,
    output logic [N_PORTS-1:0]    rsp_ready_o,
    output logic [LINE_W-1:0]     rsp_data_o,
    output logic                  down_req_valid_o,
    output logic                  down_req_rw_o,
    output logic [ADDR_W-1:0]     down_req_addr_o,
    output logic [LINE_W-1:0]     down_req_data_o,
    input  logic                  down_rsp_ready_i,
    input  logic [LINE_W-1:0]     down_rsp_data_i,
    output logic [N_PORTS-1:0]    grant_o,
    output logic                  busy_o
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_state_e           r_state;
    arb_state_e           w_next;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        w_ptr_in;
    logic [N_PORTS-1:0]   w_pick;
    logic [PW-1:0]        w_win;
    logic                 w_start;
    logic [N_PORTS-1:0]   r_grant;
    logic                 r_rw;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_W-1:0]    r_data;
    logic [LINE_W-1:0]    r_rsp_data;
    logic                 w_down_valid;
    logic                 w_busy;
    logic [N_PORTS-1:0]   w_rsp_ready;

    assign w_ptr_in = (RR_MODE != 0) ? r_ptr : '0;
    assign w_start  = (r_state == IDLE) && (|req_valid_i);

    rr_priority_picker #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (w_ptr_in),
        .grant_o (w_pick)
    );

    // One-hot grant to winner index.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_pick[i]) begin
                w_win = PW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = BUSY;
            BUSY:    if (down_rsp_ready_i) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture the winner's request; clear ownership after the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_pick;
                r_rw    <= req_rw_i[w_win];
                r_addr  <= req_addr_i[w_win*ADDR_W +: ADDR_W];
                r_data  <= req_data_i[w_win*LINE_W +: LINE_W];
                if (RR_MODE != 0) begin
                    if (w_win == PW'(N_PORTS - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_win + 1'b1;
                    end
                end
            end
            if (r_state == BUSY && down_rsp_ready_i) begin
                r_rsp_data <= down_rsp_data_i;
            end
            if (r_state == RESP) begin
                r_grant <= '0;
            end
        end
    end

    // State-decoded outputs.
    always_comb begin
        w_down_valid = (r_state == BUSY);
        w_busy       = (r_state != IDLE);
        w_rsp_ready  = (r_state == RESP) ? r_grant : '0;
    end

    assign rsp_ready_o      = w_rsp_ready;
    assign rsp_data_o       = r_rsp_data;
    assign down_req_valid_o = w_down_valid;
    assign down_req_rw_o    = r_rw;
    assign down_req_addr_o  = r_addr;
    assign down_req_data_o  = r_data;
    assign grant_o          = r_grant;
    assign busy_o           = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance
// plus a fixed-priority instance, both with four ports.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid;
    logic [N-1:0]    rw;
    logic [N*AW-1:0] addr;
    logic [N*LW-1:0] data;
    logic            drdy;
    logic [LW-1:0]   ddata;
    logic [N-1:0]    rsp_ready;
    logic [LW-1:0]   rsp_data;
    logic            dvalid;
    logic            drw;
    logic [AW-1:0]   daddr;
    logic [LW-1:0]   dwdata;
    logic [N-1:0]    grant;
    logic            busy;

    logic [N-1:0]    fp_valid;
    logic            fp_drdy;
    logic [N-1:0]    fp_rsp_ready;
    logic [LW-1:0]   fp_rsp_data;
    logic            fp_dvalid;
    logic            fp_drw;
    logic [AW-1:0]   fp_daddr;
    logic [LW-1:0]   fp_dwdata;
    logic [N-1:0]    fp_grant;
    logic            fp_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [LW-1:0] DEADBEEF =
        128'hDEAD_0000_1234_5678_9ABC_0000_0000_BEEF;
    localparam logic [LW-1:0] ONES = {32{4'h1}};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .N_PORTS (N), .ADDR_W (AW), .LINE_W (LW), .RR_MODE (1)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (valid),
        .req_rw_i         (rw),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .rsp_ready_o      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .down_req_valid_o (dvalid),
        .down_req_rw_o    (drw),
        .down_req_addr_o  (daddr),
        .down_req_data_o  (dwdata),
        .down_rsp_ready_i (drdy),
        .down_rsp_data_i  (ddata),
        .grant_o          (grant),
        .busy_o           (busy)
    );

    mem_port_arbiter #(
        .N_PORTS (N), .ADDR_W (AW), .LINE_W (LW), .RR_MODE (0)
    ) u_fp (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (fp_valid),
        .req_rw_i         (rw),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .rsp_ready_o      (fp_rsp_ready),
        .rsp_data_o       (fp_rsp_data),
        .down_req_valid_o (fp_dvalid),
        .down_req_rw_o    (fp_drw),
        .down_req_addr_o  (fp_daddr),
        .down_req_data_o  (fp_dwdata),
        .down_rsp_ready_i (fp_drdy),
        .down_rsp_data_i  (ddata),
        .grant_o          (fp_grant),
        .busy_o           (fp_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        valid = '0; rw = '0; addr = '0; data = '0;
        drdy = 1'b0; ddata = '0; fp_valid = '0; fp_drdy = 1'b0;
        do_reset();
        checks++;
        if ({rsp_ready, rsp_data, dvalid, drw, daddr, dwdata,
             grant, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b dvalid=%b",
                     grant, busy, dvalid);
        end
        checks++;
        if (fp_grant !== '0 || fp_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fp: grant=%b busy=%b",
                     fp_grant, fp_busy);
        end
    endtask

    task automatic test_single_read();
        valid[0] = 1'b1; rw[0] = 1'b0;
        addr[0*AW +: AW] = 32'h0000_0040;
        step();
        checks++;
        if (dvalid !== 1'b1 || daddr !== 32'h40 || grant !== 4'b0001
            || drw !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_req: dvalid=%b addr=%h grant=%b need 1 40 0001",
                     dvalid, daddr, grant);
        end
        step();
        step();
        drdy = 1'b1; ddata = DEADBEEF;
        step();
        checks++;
        if (rsp_ready !== 4'b0001 || rsp_data !== DEADBEEF
            || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp: rdy=%b data=%h need 0001 %h",
                     rsp_ready, rsp_data, DEADBEEF);
        end
        drdy = 1'b0; ddata = '0; valid = '0;
        step();
        checks++;
        if (rsp_ready !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: rdy=%b grant=%b busy=%b need 0",
                     rsp_ready, grant, busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        pulses = 0;
        valid[1] = 1'b1; rw[1] = 1'b1;
        addr[1*AW +: AW] = 32'h0000_1230;
        data[1*LW +: LW] = ONES;
        step();
        checks++;
        if (grant !== 4'b0010 || dvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_grant: grant=%b need 0010", grant);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid = '0;
        checks++;
        if ({rsp_ready, rsp_data, dvalid, drw, daddr, dwdata,
             grant, busy} !== '0) begin
            errors++;
            $display("FAIL rstbusy_outputs: grant=%b busy=%b addr=%h data=%h",
                     grant, busy, daddr, rsp_data);
        end
        drdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_ready[1] === 1'b1 || busy !== 1'b0) pulses++;
            drdy = 1'b0;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstbusy_nopulse: bad cycles=%0d need 0", pulses);
        end
    endtask

    task automatic test_spurious();
        valid = '0;
        drdy = 1'b1; ddata = DEADBEEF;
        step();
        checks++;
        if (rsp_ready !== '0 || busy !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL spurious: rdy=%b busy=%b need 0 0",
                     rsp_ready, busy);
        end
        drdy = 1'b0; ddata = '0;
        step();
        checks++;
        if (busy !== 1'b0 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: busy=%b dvalid=%b need 0 0",
                     busy, dvalid);
        end
    endtask

    task automatic test_write_capture();
        int bad;
        bad = 0;
        do_reset();
        valid[1] = 1'b1; rw[1] = 1'b1;
        addr[1*AW +: AW] = 32'h0000_0080;
        data[1*LW +: LW] = ONES;
        step();
        checks++;
        if (grant !== 4'b0010 || drw !== 1'b1 || daddr !== 32'h80
            || dwdata !== ONES) begin
            errors++;
            $display("FAIL wr_capture: grant=%b rw=%b addr=%h data=%h",
                     grant, drw, daddr, dwdata);
        end
        data[1*LW +: LW] = {32{4'h7}};
        addr[1*AW +: AW] = 32'h0000_0F00;
        rw[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dwdata !== ONES || daddr !== 32'h80 || drw !== 1'b1
                || dvalid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wr_stable: bad cycles=%0d data=%h need %h",
                     bad, dwdata, ONES);
        end
        drdy = 1'b1;
        step();
        checks++;
        if (rsp_ready !== 4'b0010 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp: rdy=%b dvalid=%b need 0010 0",
                     rsp_ready, dvalid);
        end
        drdy = 1'b0; valid = '0;
        step();
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] exp;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = '0;
            exp[order[i]] = 1'b1;
            step();
            checks++;
            if (grant !== exp || dvalid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: grant=%b need %b", i, grant, exp);
            end
            drdy = 1'b1;
            step();
            checks++;
            if (rsp_ready !== exp) begin
                errors++;
                $display("FAIL rr_rsp%0d: rdy=%b need %b", i, rsp_ready, exp);
            end
            drdy = 1'b0;
            step();
        end
        valid = '0;
    endtask

    task automatic test_fixed_priority();
        int bad;
        bad = 0;
        do_reset();
        fp_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            if (fp_grant !== 4'b0001) bad++;
            fp_drdy = 1'b1;
            step();
            if (fp_rsp_ready !== 4'b0001) bad++;
            fp_drdy = 1'b0;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fixed_prio: bad samples=%0d last grant=%b need 0001",
                     bad, fp_grant);
        end
        fp_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid[2] = 1'b1; rw[2] = 1'b0;
        addr[2*AW +: AW] = 32'h0000_0100;
        step();
        drdy = 1'b1;
        step();
        drdy = 1'b0;
        addr[2*AW +: AW] = 32'h0000_0140;
        step();
        step();
        checks++;
        if (grant !== 4'b0100 || daddr !== 32'h140 || dvalid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: grant=%b addr=%h need 0100 140",
                     grant, daddr);
        end
        drdy = 1'b1;
        step();
        drdy = 1'b0; valid = '0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_reset_mid_busy();
        test_spurious();
        test_write_capture();
        test_rr_fairness();
        test_fixed_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
